// File: rtl/mcu_port_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mcu_port_uart_pkg
// Description : Shared constants for the MCU port UART: register addresses,
//               STATUS/CONTROL bit positions and TX/RX state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package mcu_port_uart_pkg;

  // Register select values decoded from port0[1:0]; address 3 is reserved.
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  // STATUS register bit positions (bit 7 always reads 0).
  localparam int ST_TX_EMPTY  = 0;
  localparam int ST_TX_FULL   = 1;
  localparam int ST_RX_AVAIL  = 2;
  localparam int ST_RX_FULL   = 3;
  localparam int ST_RX_OVERRUN = 4;
  localparam int ST_FRAME_ERR = 5;
  localparam int ST_TX_BUSY   = 6;

  // CONTROL register bit positions.
  localparam int CTRL_CLEAR = 0;
  localparam int CTRL_FLUSH = 1;
  localparam int CTRL_LOOP  = 2;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/mcu_port_uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock 8-bit FIFO with 2**FIFO_AW entries. Head data is
//               presented combinationally. A push into a full FIFO is accepted
//               only when a pop happens in the same cycle. Flush empties it.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int FIFO_AW = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  input  logic       flush,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush discards everything.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/mcu_port_uart.sv
`default_nettype none
// ============================================================================
// Module      : mcu_port_uart
// Description : 8N1 UART peripheral on the MCU port interface. port0 selects
//               DATA/STATUS/CONTROL, port1+strobe1 write, port2 reads with
//               strobe2 as read acknowledge. TX and RX each use a sync_fifo.
//               Optional internal loopback: MCU_PORT_UART_LOOPBACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mcu_port_uart
  import mcu_port_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] port0_i,
  input  logic [7:0] port1_i,
  input  logic       strobe1_i,
  output logic [7:0] port2_o,
  input  logic       strobe2_i,
  output logic       uart_tx_o,
  input  logic       uart_rx_i
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  // ---------------- register decode ----------------
  logic [1:0] sel;
  logic       data_wr, ctrl_wr, flush, clr_flags, rx_pop;
  logic       unused_bits;

  assign sel       = port0_i[1:0];
  assign data_wr   = strobe1_i & (sel == REG_DATA);
  assign ctrl_wr   = strobe1_i & (sel == REG_CTRL);
  assign flush     = ctrl_wr & port1_i[CTRL_FLUSH];
  assign clr_flags = ctrl_wr & port1_i[CTRL_CLEAR];
  assign rx_pop    = strobe2_i & (sel == REG_DATA);
  assign unused_bits = ^{port0_i[7:2], port1_i[7:2]};

  // ---------------- FIFOs ----------------
  logic [7:0] tx_head, rx_head, rx_shift;
  logic       tx_full, tx_empty, tx_pop;
  logic       rx_full, rx_empty, rx_good, rx_ferr;

  sync_fifo #(.FIFO_AW(FIFO_AW)) u_tx_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni), .push(data_wr), .wdata(port1_i),
    .pop(tx_pop), .flush(flush), .rdata(tx_head), .full(tx_full), .empty(tx_empty)
  );

  sync_fifo #(.FIFO_AW(FIFO_AW)) u_rx_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni), .push(rx_good), .wdata(rx_shift),
    .pop(rx_pop), .flush(flush), .rdata(rx_head), .full(rx_full), .empty(rx_empty)
  );

  // ---------------- TX FSM ----------------
  tx_state_e        tx_state, tx_state_n;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]       tx_bit, tx_bit_n;
  logic [7:0]       tx_shift, tx_shift_n;
  logic             tx_line, tx_line_n;

  // TX state and datapath registers; the line idles high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx_line  <= tx_line_n;
    end
  end

  // TX next state: pop a byte from IDLE, then start/8 data/stop bit periods.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_pop     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!tx_empty && !flush) begin
          tx_pop     = 1'b1;
          tx_shift_n = tx_head;
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_state_n = TX_DATA;
        end else tx_cnt_n = tx_cnt + 1'b1;
      end
      TX_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n = '0;
          if (tx_bit == 3'd7) tx_state_n = TX_STOP;
          else begin
            tx_bit_n   = tx_bit + 3'd1;
            tx_shift_n = {1'b0, tx_shift[7:1]};
          end
        end else tx_cnt_n = tx_cnt + 1'b1;
      end
      TX_STOP: begin
        if (tx_cnt == BIT_LAST) tx_state_n = TX_IDLE;
        else tx_cnt_n = tx_cnt + 1'b1;
      end
      default: tx_state_n = TX_IDLE;
    endcase
    // The line register follows the next state so line and state move together.
    case (tx_state_n)
      TX_START: tx_line_n = 1'b0;
      TX_DATA:  tx_line_n = tx_shift_n[0];
      default:  tx_line_n = 1'b1;
    endcase
  end

  // ---------------- loopback option ----------------
  logic loop_en;
  logic rx_src;
`ifdef MCU_PORT_UART_LOOPBACK_EN
  // Loopback enable, written through CONTROL.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) loop_en <= 1'b0;
    else if (ctrl_wr) loop_en <= port1_i[CTRL_LOOP];
  end
  assign rx_src    = loop_en ? tx_line : uart_rx_i;
  assign uart_tx_o = loop_en ? 1'b1 : tx_line;
`else
  assign loop_en   = 1'b0;
  assign rx_src    = uart_rx_i;
  assign uart_tx_o = tx_line;
`endif

  // ---------------- RX path ----------------
  logic [1:0]       rx_sync;
  logic             rx_s, rx_prev;
  rx_state_e        rx_state, rx_state_n;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]       rx_bit, rx_bit_n;
  logic [7:0]       rx_shift_n;

  assign rx_s = rx_sync[1];

  // Synchronizer, edge history and RX state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_sync  <= 2'b11;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_sync  <= {rx_sync[0], rx_src};
      rx_prev  <= rx_s;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  // RX next state: confirm start at half bit, then sample each bit mid-period.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_good    = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_s) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n   = '0;
          rx_state_n = rx_s ? RX_IDLE : RX_DATA;
        end else rx_cnt_n = rx_cnt + 1'b1;
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          else rx_bit_n = rx_bit + 3'd1;
        end else rx_cnt_n = rx_cnt + 1'b1;
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_good    = rx_s;
          rx_ferr    = ~rx_s;
          rx_state_n = RX_IDLE;
        end else rx_cnt_n = rx_cnt + 1'b1;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // ---------------- sticky flags ----------------
  logic overrun, frame_err;

  // Sticky error flags; a new error in the clearing cycle wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (clr_flags) begin
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      if (rx_good && rx_full && !rx_pop) overrun <= 1'b1;
      if (rx_ferr) frame_err <= 1'b1;
    end
  end

  // ---------------- read mux ----------------
  logic [7:0] status;

  // STATUS register assembly.
  always_comb begin
    status                = 8'h00;
    status[ST_TX_EMPTY]   = tx_empty;
    status[ST_TX_FULL]    = tx_full;
    status[ST_RX_AVAIL]   = ~rx_empty;
    status[ST_RX_FULL]    = rx_full;
    status[ST_RX_OVERRUN] = overrun;
    status[ST_FRAME_ERR]  = frame_err;
    status[ST_TX_BUSY]    = (tx_state != TX_IDLE);
  end

  // Combinational read data for the selected register.
  always_comb begin
    port2_o = 8'h00;
    case (sel)
      REG_DATA:   port2_o = rx_empty ? 8'h00 : rx_head;
      REG_STATUS: port2_o = status;
      REG_CTRL:   port2_o[CTRL_LOOP] = loop_en;
      default:    port2_o = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mcu_port_uart.sv
`default_nettype none
// ============================================================================
// Module      : tb_mcu_port_uart
// Description : Scoreboard bench for mcu_port_uart. Register reads and TX
//               frames are queued as expectations by the stimulus and checked
//               by independent monitors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mcu_port_uart;

  logic       clk_i;
  logic       rst_ni;
  logic [7:0] port0_i;
  logic [7:0] port1_i;
  logic       strobe1_i;
  logic [7:0] port2_o;
  logic       strobe2_i;
  logic       uart_tx_o;
  logic       uart_rx_i;

  int errors = 0;
  int checks = 0;
  int tx_frames = 0;
  logic tx_mon_off = 1'b0;

  logic [7:0] rd_exp_q [$];
  string      rd_name_q [$];
  logic [7:0] tx_exp_q [$];

  localparam logic [7:0] TX_TAB [17] = '{8'hA5, 8'h5A, 8'h00, 8'hFF, 8'h01, 8'h80,
    8'h3C, 8'hC3, 8'h96, 8'h69, 8'h0F, 8'hF0, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
  localparam logic [7:0] RX_TAB [17] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
    8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h01, 8'h02};

  mcu_port_uart #(.CLKS_PER_BIT(16), .FIFO_AW(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .port0_i(port0_i), .port1_i(port1_i),
    .strobe1_i(strobe1_i), .port2_o(port2_o), .strobe2_i(strobe2_i),
    .uart_tx_o(uart_tx_o), .uart_rx_i(uart_rx_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    port0_i   = {6'd0, a};
    port1_i   = d;
    strobe1_i = 1'b1;
    tick();
    strobe1_i = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] e, input string n);
    rd_exp_q.push_back(e);
    rd_name_q.push_back(n);
    port0_i   = {6'd0, a};
    strobe2_i = 1'b1;
    tick();
    strobe2_i = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    uart_rx_i = 1'b0;
    repeat (16) tick();
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      repeat (16) tick();
    end
    uart_rx_i = stop;
    repeat (16) tick();
    uart_rx_i = 1'b1;
  endtask

  // Read monitor: every acknowledged read is compared with the queued value.
  logic [7:0] mon_e;
  string      mon_n;
  always @(negedge clk_i) begin
    if (strobe2_i) begin
      if (rd_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got 0x%0h expected no read", port2_o);
      end else begin
        mon_e = rd_exp_q.pop_front();
        mon_n = rd_name_q.pop_front();
        check(mon_n, {24'd0, port2_o}, {24'd0, mon_e});
      end
    end
  end

  // TX monitor: decodes frames on uart_tx_o at mid-bit and scores them.
  initial begin : tx_monitor
    logic [7:0] got;
    logic       start_lo;
    logic       stop_b;
    logic [7:0] e;
    forever begin
      @(negedge clk_i);
      if (rst_ni && !uart_tx_o && !tx_mon_off) begin
        repeat (8) @(negedge clk_i);
        start_lo = ~uart_tx_o;
        for (int b = 0; b < 8; b++) begin
          repeat (16) @(negedge clk_i);
          got[b] = uart_tx_o;
        end
        repeat (16) @(negedge clk_i);
        stop_b = uart_tx_o;
        if (!tx_mon_off) begin
          tx_frames++;
          check("tx_start_bit", {31'd0, start_lo}, 32'd1);
          check("tx_stop_bit", {31'd0, stop_b}, 32'd1);
          if (tx_exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected_frame: got 0x%0h expected none", got);
          end else begin
            e = tx_exp_q.pop_front();
            check("tx_frame_byte", {24'd0, got}, {24'd0, e});
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int   first;
    int   busy_cnt;
    int   wave_err;
    int   k;
    int   f0;
    int   lowc;
    logic exp_b;
    logic done;
    logic [7:0] pat;

    rst_ni    = 1'b0;
    port0_i   = 8'h00;
    port1_i   = 8'h00;
    strobe1_i = 1'b0;
    strobe2_i = 1'b0;
    uart_rx_i = 1'b1;
    repeat (3) tick();
    check("reset_tx_line", {31'd0, uart_tx_o}, 32'd1);
    rst_ni = 1'b1;
    tick();

    // Reset register view.
    rd(2'd0, 8'h00, "reset_data");
    rd(2'd1, 8'h01, "reset_status");
    rd(2'd2, 8'h00, "reset_ctrl");
    wr(2'd3, 8'hFF);
    rd(2'd3, 8'h00, "reserved_read");
    rd(2'd1, 8'h01, "status_after_reserved_wr");

    // Single 0x55 frame: exact waveform and busy duration.
    pat = 8'h55;
    tx_exp_q.push_back(pat);
    wr(2'd0, pat);
    port0_i  = 8'd1;
    first    = -1;
    busy_cnt = 0;
    wave_err = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk_i);
      if (port2_o[6]) busy_cnt++;
      if (first < 0 && !uart_tx_o) first = c;
      if (first >= 0 && (c - first) < 170) begin
        k = c - first;
        if (k < 16) exp_b = 1'b0;
        else if (k < 144) exp_b = pat[(k - 16) / 16];
        else exp_b = 1'b1;
        if (uart_tx_o !== exp_b) wave_err++;
      end
    end
    check("tx_launch_latency", first, 1);
    check("tx_wave_bad_cycles", wave_err, 0);
    check("tx_busy_cycles", busy_cnt, 160);
    tick();

    // 17 back-to-back writes: one launches, sixteen queue, 18th dropped.
    f0 = tx_frames;
    for (int i = 0; i < 17; i++) begin
      tx_exp_q.push_back(TX_TAB[i]);
      wr(2'd0, TX_TAB[i]);
    end
    rd(2'd1, 8'h42, "status_tx_full");
    wr(2'd0, 8'hEE);
    rd(2'd1, 8'h42, "status_after_drop");
    port0_i = 8'd1;
    done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge clk_i);
      if (port2_o[0] && !port2_o[6]) done = 1'b1;
    end
    check("tx_drain_done", {31'd0, done}, 32'd1);
    repeat (2) tick();
    check("tx_frames_17", tx_frames - f0, 17);
    check("tx_queue_drained", tx_exp_q.size(), 0);

    // Single RX frame.
    send_rx(8'hA3, 1'b1);
    repeat (4) tick();
    rd(2'd1, 8'h05, "rx_status_avail");
    rd(2'd0, 8'hA3, "rx_data_a3");
    rd(2'd0, 8'h00, "rx_data_after_pop");
    rd(2'd1, 8'h01, "rx_status_empty");

    // RX overflow: 17 frames, no reads.
    for (int i = 0; i < 17; i++) send_rx(RX_TAB[i], 1'b1);
    repeat (4) tick();
    rd(2'd1, 8'h1D, "rx_status_full_overrun");
    for (int i = 0; i < 16; i++) rd(2'd0, RX_TAB[i], "rx_fifo_order");
    rd(2'd1, 8'h11, "rx_status_overrun_only");
    wr(2'd2, 8'h01);
    rd(2'd1, 8'h01, "rx_overrun_cleared");

    // Framing error followed by a short glitch.
    send_rx(8'h5A, 1'b0);
    repeat (4) tick();
    uart_rx_i = 1'b0;
    repeat (4) tick();
    uart_rx_i = 1'b1;
    repeat (40) tick();
    rd(2'd1, 8'h21, "frame_err_status");
    rd(2'd0, 8'h00, "frame_err_no_byte");
    wr(2'd2, 8'h01);
    rd(2'd1, 8'h01, "frame_err_cleared");

    // Flush of a received byte.
    send_rx(8'h77, 1'b1);
    repeat (4) tick();
    rd(2'd1, 8'h05, "pre_flush_status");
    wr(2'd2, 8'h02);
    rd(2'd1, 8'h01, "post_flush_status");
    rd(2'd0, 8'h00, "post_flush_data");

`ifdef MCU_PORT_UART_LOOPBACK_EN
    wr(2'd2, 8'h04);
    rd(2'd2, 8'h04, "ctrl_loop_readback");
    wr(2'd0, 8'h3C);
    lowc = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk_i);
      if (!uart_tx_o) lowc++;
    end
    tick();
    check("loop_tx_stays_high", lowc, 0);
    rd(2'd1, 8'h05, "loop_rx_status");
    rd(2'd0, 8'h3C, "loop_rx_data");
    wr(2'd2, 8'h00);
    rd(2'd2, 8'h00, "ctrl_loop_off");
`else
    wr(2'd2, 8'h04);
    rd(2'd2, 8'h00, "ctrl_bit2_not_stored");
    tx_exp_q.push_back(8'h3C);
    wr(2'd0, 8'h3C);
    lowc = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk_i);
      if (!uart_tx_o) lowc++;
    end
    tick();
    check("no_loop_tx_active", {31'd0, (lowc > 0)}, 32'd1);
    rd(2'd1, 8'h01, "no_loop_rx_empty");
`endif

    // Reset in mid-frame: line high at once, queued byte lost.
    tx_mon_off = 1'b1;
    wr(2'd0, 8'h00);
    wr(2'd0, 8'h00);
    repeat (40) tick();
    check("pre_reset_line_low", {31'd0, uart_tx_o}, 32'd0);
    #2;
    rst_ni = 1'b0;
    #1;
    check("reset_mid_frame_line", {31'd0, uart_tx_o}, 32'd1);
    repeat (2) tick();
    rst_ni = 1'b1;
    tick();
    rd(2'd1, 8'h01, "status_after_mid_reset");

    repeat (5) tick();
    check("rd_queue_drained", rd_exp_q.size(), 0);
    check("tx_exp_drained", tx_exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
